// File: rtl/counter_readout_rx.sv
// -----------------------------------------------------------------------------
// counter_readout_rx
//
// Receive-side deserializer for the multi-channel impulse counter readout
// link. A low sample on sl_in marks a frame start and latches the channel
// address; the following FRAME_BITS samples of serial_in are shifted in
// MSB first. A complete frame for a channel below NCH is written to the
// channel's register bank entry. Words for channels at or above NCH are
// rejected. With parity enabled, words with bad parity are also rejected.
// A host-side port reads the bank combinationally.
//
// Optional feature macro: RX_PARITY_EN
//   defined   -> one even-parity bit follows the data bits (FRAME_BITS = WIDTH+1)
//   undefined -> FRAME_BITS = WIDTH, no parity check
//
// Ports
//   clk          system clock, all inputs sampled on the rising edge
//   rst_n        synchronous active-low reset
//   serial_in    serial data from the counter
//   sl_in        shift/load: 0 = load/frame start, 1 = shift
//   addr_in      channel address, valid while sl_in = 0
//   ovf_in       global overflow flag, accumulated over a frame
//   rtc_ovf_in   RTC overflow flag
//   clear        zeroes all valid/ovf flags, keeps bank data
//   rd_addr      host read address
//   rd_data      stored word for rd_addr (0 when rd_addr >= NCH)
//   rd_valid     word at rd_addr received since reset/clear
//   rd_ovf       ovf_in was seen during that word's frame
//   frame_valid  one-cycle pulse when a word is stored
//   frame_addr   address of the last stored or rejected frame
//   frame_err    one-cycle pulse when a frame is rejected or aborted
//   rtc_tick     one-cycle pulse after a rising edge of rtc_ovf_in
// -----------------------------------------------------------------------------
module counter_readout_rx #(
    parameter int WIDTH = 16,
    parameter int NCH   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             serial_in,
    input  logic             sl_in,
    input  logic [3:0]       addr_in,
    input  logic             ovf_in,
    input  logic             rtc_ovf_in,
    input  logic             clear,
    input  logic [3:0]       rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             rd_ovf,
    output logic             frame_valid,
    output logic [3:0]       frame_addr,
    output logic             frame_err,
    output logic             rtc_tick
);

`ifdef RX_PARITY_EN
    localparam int FRAME_BITS = WIDTH + 1;
`else
    localparam int FRAME_BITS = WIDTH;
`endif
    localparam int CW = $clog2(FRAME_BITS + 1);

    // state    | meaning
    // ST_IDLE  | after reset, waiting for the first load cycle
    // ST_SHIFT | collecting frame bits
    // ST_HOLD  | frame finished, extra shift bits ignored until next load
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t                  state_q;
    logic [CW-1:0]           cnt_q;
    logic [FRAME_BITS-1:0]   shreg_q;
    logic [3:0]              addr_q;
    logic                    ovf_acc_q;
    logic [WIDTH-1:0]        bank_q [NCH];
    logic [NCH-1:0]          valid_q;
    logic [NCH-1:0]          ovf_q;
    logic                    frame_valid_q;
    logic                    frame_err_q;
    logic [3:0]              frame_addr_q;
    logic                    rtc_q;
    logic                    rtc_tick_q;

    logic [FRAME_BITS-1:0]   shreg_d;
    logic [CW-1:0]           cnt_d;
    logic                    last_bit;
    logic [WIDTH-1:0]        word_d;
    logic                    addr_ok;
    logic                    par_ok;
    logic                    ovf_fin;

    // Next shift contents include the bit sampled this cycle, so the final
    // word and its check are taken from here rather than from shreg_q.
    assign shreg_d  = {shreg_q[FRAME_BITS-2:0], serial_in};
    assign cnt_d    = cnt_q + 1'b1;
    assign last_bit = (cnt_d == CW'(FRAME_BITS));
    assign word_d   = shreg_d[FRAME_BITS-1 -: WIDTH];
    assign addr_ok  = ({1'b0, addr_q} < 5'(NCH));
    assign ovf_fin  = ovf_acc_q | ovf_in;

`ifdef RX_PARITY_EN
    // Even parity over data plus parity bit: total number of ones is even.
    assign par_ok = ~(^shreg_d);
`else
    assign par_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            shreg_q       <= '0;
            addr_q        <= '0;
            ovf_acc_q     <= 1'b0;
            valid_q       <= '0;
            ovf_q         <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_addr_q  <= '0;
            rtc_q         <= 1'b0;
            rtc_tick_q    <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            rtc_q         <= rtc_ovf_in;
            rtc_tick_q    <= rtc_ovf_in & ~rtc_q;

            if (clear) begin
                valid_q <= '0;
                ovf_q   <= '0;
            end

            if (!sl_in) begin
                // A load right after another load has shifted nothing yet,
                // so only a partially filled frame counts as aborted.
                if (state_q == ST_SHIFT && cnt_q != '0) begin
                    frame_err_q  <= 1'b1;
                    frame_addr_q <= addr_q;
                end
                addr_q    <= addr_in;
                cnt_q     <= '0;
                shreg_q   <= '0;
                ovf_acc_q <= 1'b0;
                state_q   <= ST_SHIFT;
            end else if (state_q == ST_SHIFT) begin
                shreg_q   <= shreg_d;
                cnt_q     <= cnt_d;
                ovf_acc_q <= ovf_fin;
                if (last_bit) begin
                    state_q      <= ST_HOLD;
                    frame_addr_q <= addr_q;
                    if (addr_ok && par_ok) begin
                        frame_valid_q <= 1'b1;
                        // Placed after the clear so a same-cycle store keeps
                        // its own entry's flags.
                        for (int i = 0; i < NCH; i++) begin
                            if (addr_q == 4'(i)) begin
                                bank_q[i]  <= word_d;
                                valid_q[i] <= 1'b1;
                                ovf_q[i]   <= ovf_fin;
                            end
                        end
                    end else begin
                        frame_err_q <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        rd_data  = '0;
        rd_valid = 1'b0;
        rd_ovf   = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (rd_addr == 4'(i)) begin
                rd_data  = bank_q[i];
                rd_valid = valid_q[i];
                rd_ovf   = ovf_q[i];
            end
        end
    end

    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign frame_addr  = frame_addr_q;
    assign rtc_tick    = rtc_tick_q;

endmodule

// File: tb/tb_counter_readout_rx.sv
// -----------------------------------------------------------------------------
// tb_counter_readout_rx
//
// Directed bench for counter_readout_rx (WIDTH=16, NCH=8). Every frame end
// pushes the expected frame event into a queue; a monitor pops and compares
// whenever frame_valid or frame_err pulses. Bank contents are checked through
// the host read port. Honours RX_PARITY_EN.
// -----------------------------------------------------------------------------
module tb_counter_readout_rx;

    localparam int WIDTH = 16;
    localparam int NCH   = 8;

    typedef struct {
        logic       is_err;
        logic [3:0] addr;
    } evt_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             serial_in;
    logic             sl_in;
    logic [3:0]       addr_in;
    logic             ovf_in;
    logic             rtc_ovf_in;
    logic             clear;
    logic [3:0]       rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             rd_ovf;
    logic             frame_valid;
    logic [3:0]       frame_addr;
    logic             frame_err;
    logic             rtc_tick;

    int   total = 0;
    int   bad   = 0;
    evt_t exp_q[$];
    int   tick_cnt;

    counter_readout_rx #(.WIDTH(WIDTH), .NCH(NCH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .serial_in   (serial_in),
        .sl_in       (sl_in),
        .addr_in     (addr_in),
        .ovf_in      (ovf_in),
        .rtc_ovf_in  (rtc_ovf_in),
        .clear       (clear),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_ovf      (rd_ovf),
        .frame_valid (frame_valid),
        .frame_addr  (frame_addr),
        .frame_err   (frame_err),
        .rtc_tick    (rtc_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_evt(input logic is_err, input logic [3:0] a);
        evt_t e;
        e.is_err = is_err;
        e.addr   = a;
        exp_q.push_back(e);
    endtask

    // Frame monitor / scoreboard: any pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (frame_valid === 1'b1 || frame_err === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("evt_unexpected", 32'({frame_valid, frame_err}), 32'd0);
            end else begin
                evt_t e;
                e = exp_q.pop_front();
                check("evt_kind", 32'({frame_valid, frame_err}), 32'({~e.is_err, e.is_err}));
                check("evt_addr", 32'(frame_addr), 32'(e.addr));
            end
        end
    end

    always @(negedge clk) begin
        if (rtc_tick === 1'b1) tick_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Load cycle then data bits MSB first (plus parity when enabled).
    // ovf_pos selects which data bit carries ovf_in=1 (-1: none).
    // clr_last raises clear during the last bit; caller drops it again.
    task automatic send_frame(input logic [3:0] a, input logic [15:0] d,
                              input int ovf_pos, input bit bad_par, input bit clr_last);
        @(negedge clk);
        sl_in = 1'b0; addr_in = a; serial_in = 1'b0; ovf_in = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            @(negedge clk);
            sl_in     = 1'b1;
            serial_in = d[WIDTH-1-i];
            ovf_in    = (i == ovf_pos);
`ifndef RX_PARITY_EN
            if (i == WIDTH-1) clear = clr_last;
`endif
        end
`ifdef RX_PARITY_EN
        @(negedge clk);
        serial_in = (^d) ^ bad_par;
        ovf_in    = 1'b0;
        clear     = clr_last;
`endif
    endtask

    task automatic rd(input string tag, input logic [3:0] a, input logic [15:0] ed,
                      input logic ev, input logic eo);
        rd_addr = a;
        #1;
        check({tag, "_data"},  32'(rd_data),  32'(ed));
        check({tag, "_valid"}, 32'(rd_valid), 32'(ev));
        check({tag, "_ovf"},   32'(rd_ovf),   32'(eo));
    endtask

    initial begin
        rst_n = 1'b0; serial_in = 1'b0; sl_in = 1'b1; addr_in = 4'd0;
        ovf_in = 1'b0; rtc_ovf_in = 1'b0; clear = 1'b0; rd_addr = 4'd0;
        tick_cnt = 0;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_frame_valid", 32'(frame_valid), 32'd0);
        check("rst_frame_err",   32'(frame_err),   32'd0);
        check("rst_frame_addr",  32'(frame_addr),  32'd0);
        check("rst_rtc_tick",    32'(rtc_tick),    32'd0);
        rd("rst_rd3", 4'd3, 16'h0000, 1'b0, 1'b0);
        rst_n = 1'b1;

        // basic frame
        push_evt(1'b0, 4'd3);
        send_frame(4'd3, 16'hA5C3, -1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("t1_frame_addr", 32'(frame_addr), 32'd3);
        rd("t1_rd3", 4'd3, 16'hA5C3, 1'b1, 1'b0);
        rd("t1_rd2", 4'd2, 16'h0000, 1'b0, 1'b0);

        // aborted partial frame followed by a full frame
        push_evt(1'b1, 4'd5);
        push_evt(1'b0, 4'd1);
        @(negedge clk);
        sl_in = 1'b0; addr_in = 4'd5;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            sl_in = 1'b1; serial_in = 1'b1;
        end
        send_frame(4'd1, 16'h0001, -1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rd("t2_rd5", 4'd5, 16'h0000, 1'b0, 1'b0);
        rd("t2_rd1", 4'd1, 16'h0001, 1'b1, 1'b0);

        // out-of-range channel
        push_evt(1'b1, 4'd9);
        send_frame(4'd9, 16'hBEEF, -1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("t3_frame_addr", 32'(frame_addr), 32'd9);
        rd("t3_rd9", 4'd9, 16'h0000, 1'b0, 1'b0);

        // overflow capture, then clear
        push_evt(1'b0, 4'd0);
        send_frame(4'd0, 16'h1234, 5, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rd("t4_rd0_pre", 4'd0, 16'h1234, 1'b1, 1'b1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        rd("t4_rd0_post", 4'd0, 16'h1234, 1'b0, 1'b0);
        rd("t4_rd3_post", 4'd3, 16'hA5C3, 1'b0, 1'b0);

        // two consecutive load cycles: only the second address is used
        push_evt(1'b0, 4'd4);
        @(negedge clk);
        sl_in = 1'b0; addr_in = 4'd6;
        send_frame(4'd4, 16'h00F0, -1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rd("t5_rd4", 4'd4, 16'h00F0, 1'b1, 1'b0);
        rd("t5_rd6", 4'd6, 16'h0000, 1'b0, 1'b0);

        // eight back-to-back frames
        for (int n = 0; n < 8; n++) begin
            push_evt(1'b0, 4'(n));
            send_frame(4'(n), 16'(16'h1111 * (n + 1)), -1, 1'b0, 1'b0);
        end
        repeat (2) @(negedge clk);
        for (int n = 0; n < 8; n++) begin
            rd($sformatf("t6_rd%0d", n), 4'(n), 16'(16'h1111 * (n + 1)), 1'b1, 1'b0);
        end

        // rtc edge detect: 3 cycles high gives one tick
        tick_cnt = 0;
        @(negedge clk);
        rtc_ovf_in = 1'b1;
        repeat (3) @(negedge clk);
        rtc_ovf_in = 1'b0;
        repeat (3) @(negedge clk);
        check("t7_rtc_ticks", 32'(tick_cnt), 32'd1);

        // clear coinciding with a store: stored entry keeps its flags
        push_evt(1'b0, 4'd2);
        send_frame(4'd2, 16'hC0DE, 3, 1'b0, 1'b1);
        @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
        rd("t8_rd2", 4'd2, 16'hC0DE, 1'b1, 1'b1);
        rd("t8_rd5", 4'd5, 16'h6666, 1'b0, 1'b0);

`ifdef RX_PARITY_EN
        push_evt(1'b1, 4'd6);
        send_frame(4'd6, 16'h00FF, -1, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        rd("t9_rd6_bad", 4'd6, 16'h7777, 1'b0, 1'b0);
        push_evt(1'b0, 4'd6);
        send_frame(4'd6, 16'h00FF, -1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rd("t9_rd6_good", 4'd6, 16'h00FF, 1'b1, 1'b0);
`endif

        // reset mid-frame: no pulse, bank zeroed
        @(negedge clk);
        sl_in = 1'b0; addr_in = 4'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            sl_in = 1'b1; serial_in = 1'b1;
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (WIDTH + 3) @(negedge clk);
        rd("t10_rd1", 4'd1, 16'h0000, 1'b0, 1'b0);
        check("t10_frame_addr", 32'(frame_addr), 32'd0);

        check("evt_missing", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/counter_readout_rx.md
# counter_readout_rx

Receive-side deserializer for the multi-channel impulse counter readout link. It samples the serial data, shift/load and channel-address lines driven by the counter chip, and rebuilds each channel's count word. Completed words land in a per-channel register bank that a host-side read port can access. It sits on the board-side FPGA or test harness, at the far end of the counter's serial readout.

## Interface
Parameters:
- WIDTH, 16, bits per counter word, sent MSB first
- NCH, 8, number of channels stored (1..16)

Ports:
- clk  in  1  single system clock; all inputs sampled on rising edge
- rst_n  in  1  reset, synchronous, active-low
- serial_in  in  1  serial data from the counter
- sl_in  in  1  shift/load: 0 = load/frame start, 1 = shift
- addr_in  in  4  channel address; valid when sl_in=0
- ovf_in  in  1  global overflow flag from the counter
- rtc_ovf_in  in  1  RTC overflow flag from the counter
- clear  in  1  synchronous clear of all valid/ovf flags
- rd_addr  in  4  host read address
- rd_data  out  WIDTH  stored word for rd_addr (combinational read)
- rd_valid  out  1  word at rd_addr received since reset/clear
- rd_ovf  out  1  ovf_in was high during that word's frame
- frame_valid  out  1  one-cycle pulse when a word is stored
- frame_addr  out  4  address of the last stored or rejected frame
- frame_err  out  1  one-cycle pulse when a frame is rejected
- rtc_tick  out  1  one-cycle pulse on rtc_ovf_in rising edge

## Operation
- The FSM has three states: IDLE, SHIFT and HOLD.
- In any state, sampling sl_in=0 does the following:
  - latches addr_in into addr_q;
  - clears the bit counter and the shift register;
  - clears ovf_acc;
  - goes to SHIFT.
- If that sl_in=0 arrives while in SHIFT, the partial frame is aborted: frame_err pulses and frame_addr takes the old addr_q.
- SHIFT: each cycle with sl_in=1, shift serial_in into the LSB and increment the bit counter. ovf_acc |= ovf_in.
- When the counter reaches FRAME_BITS (WIDTH, or WIDTH+1 with parity), the frame completes:
  - if addr_q < NCH: write to bank[addr_q], set valid[addr_q], set ovf[addr_q]=ovf_acc, pulse frame_valid;
  - otherwise: pulse frame_err and do not write.
  - Either way, frame_addr=addr_q and the FSM goes to HOLD.
- HOLD: ignore extra shift bits and wait for sl_in=0.
- Reads: rd_addr >= NCH returns rd_data=0, rd_valid=0, rd_ovf=0.
- clear=1 zeroes valid[] and ovf[]; bank data is kept.
- If clear and a store happen in the same cycle, the store wins for its own entry.
- rtc_tick = rtc_ovf_in & ~rtc_q, where rtc_q is a registered copy of rtc_ovf_in.

## Timing
- Reset (rst_n=0 at an edge) puts the FSM in IDLE and zeroes the following:
  - all bank words, valid[], ovf[];
  - frame_valid, frame_err, frame_addr, rtc_tick, rtc_q.
- A reset mid-frame discards the frame with no pulse.
- Frame timing:
  - the load cycle is sampled at edge t;
  - data bits are sampled at edges t+1 .. t+FRAME_BITS;
  - the bank write and the frame_valid/frame_err pulse are visible after edge t+FRAME_BITS, for exactly one cycle.
- rd_data, rd_valid and rd_ovf reflect a new write in the cycle after the write edge.
- Back-to-back frames: a load cycle may directly follow the last data bit. No dead cycle is required.
- Two consecutive load cycles: the second one restarts the frame with the new address. No error, because no bit has been shifted yet.
- rtc_tick is asserted one cycle after the rising edge of rtc_ovf_in is sampled.

## Configuration
- RX_PARITY_EN defined:
  - the transmitter appends one even-parity bit after the WIDTH data bits, so FRAME_BITS = WIDTH+1;
  - a parity mismatch gives frame_err, no write, and frame_addr=addr_q.
- RX_PARITY_EN undefined:
  - FRAME_BITS = WIDTH;
  - no parity logic is present.

## Test plan
- Reset, then frame addr=3, data 0xA5C3, ovf_in=0 → one frame_valid pulse, frame_addr=3. Then rd_addr=3 gives rd_data=0xA5C3, rd_valid=1, rd_ovf=0. Other addresses read rd_valid=0.
- Load addr=5, 7 data bits, then sl_in=0 with addr=1 and a full frame 0x0001 → frame_err pulse with frame_addr=5, then frame_valid with frame_addr=1. bank[5] is untouched.
- Frame addr=9 with NCH=8 → frame_err, no write. rd_addr=9 returns 0/0/0.
- Frame addr=0 with ovf_in pulsed high mid-frame, then clear=1 → rd_ovf=1 before clear, rd_valid=rd_ovf=0 after clear, rd_data unchanged.
- Eight back-to-back frames, addr 0..7, data 0x1111·(n+1), no gap cycles → eight frame_valid pulses and all entries correct. A 3-cycle rtc_ovf_in high gives exactly one rtc_tick.
- With RX_PARITY_EN: frame 0x00FF with parity bit 1 (wrong) → frame_err. The same frame with parity 0 → stored.
